// File: rtl/cim_cmd_scheduler.sv
// Compute command FIFO + presenter for the MUL controller, with load/store column hazard gating.
// Optional CIM_SCHED_PERF_EN adds saturating perf_issued / perf_stall counters.
module cim_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 6,
  parameter int CMD_W      = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_cmp_valid,
  output logic              host_cmp_ready,
  input  logic [CMD_W-1:0]  host_cmp_cmd,
  input  logic              host_ls_valid,
  output logic              host_ls_ready,
  input  logic [ADDR_W:0]   host_ls_cmd,
  input  logic              drain,
  output logic              idle,
  output logic              Compute_valid,
  input  logic              Compute_ready,
  output logic [CMD_W-1:0]  Compute_command,
  output logic              ExLdSt_valid,
  output logic [ADDR_W:0]   ExLdSt_command
`ifdef CIM_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t             state_reg;
  logic               compute_valid_reg;
  logic [CMD_W-1:0]   compute_cmd_reg;
  logic               ls_valid_reg;
  logic [ADDR_W:0]    ls_cmd_reg;
  logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CMD_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic               fifo_empty, fifo_full, push, pop;
  logic [CMD_W-1:0]   fifo_head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  // Ready is held low during reset so nothing is accepted before the FIFO is known empty.
  assign host_cmp_ready = rst_n & ~fifo_full & ~drain;
  // NOP commands complete the host handshake but never enter the FIFO.
  assign push = host_cmp_valid & host_cmp_ready & (host_cmp_cmd[CMD_W-2 -: 3] != 3'b000);
  assign pop  = ~fifo_empty & ((state_reg == ST_IDLE) ||
                               ((state_reg == ST_PRESENT) && Compute_ready));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= host_cmp_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      compute_valid_reg <= 1'b0;
      compute_cmd_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            compute_cmd_reg   <= fifo_head;
            compute_valid_reg <= 1'b1;
            state_reg         <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // The command only changes on a completed handshake; a stalled MUL sees it frozen.
          if (Compute_ready) begin
            if (!fifo_empty) begin
              compute_cmd_reg <= fifo_head;
            end else begin
              compute_valid_reg <= 1'b0;
              state_reg         <= ST_IDLE;
            end
          end
        end
        default: begin
          state_reg         <= ST_IDLE;
          compute_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  logic              cmd_special;
  logic [2:0]        cmd_mode;
  logic [ADDR_W-1:0] cmd_rs1, cmd_rs2, cmd_rd, ls_addr;
  logic              exact_hit, pair_hit, hazard;

  assign cmd_special = compute_cmd_reg[CMD_W-1];
  assign cmd_mode    = compute_cmd_reg[CMD_W-2 -: 3];
  assign cmd_rs1     = compute_cmd_reg[3*ADDR_W-1 -: ADDR_W];
  assign cmd_rs2     = compute_cmd_reg[2*ADDR_W-1 -: ADDR_W];
  assign cmd_rd      = compute_cmd_reg[ADDR_W-1:0];
  assign ls_addr     = host_ls_cmd[ADDR_W-1:0];

  assign exact_hit = (ls_addr == cmd_rs1) || (ls_addr == cmd_rs2) || (ls_addr == cmd_rd);
  // Special ADD/SUB operate on even/odd column pairs for rs2 and rd.
  assign pair_hit  = cmd_special && ((cmd_mode == 3'b101) || (cmd_mode == 3'b110)) &&
                     ((ls_addr[ADDR_W-1:1] == cmd_rs2[ADDR_W-1:1]) ||
                      (ls_addr[ADDR_W-1:1] == cmd_rd[ADDR_W-1:1]));
  assign hazard    = compute_valid_reg & (exact_hit | pair_hit);

  assign host_ls_ready = ~hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_valid_reg <= 1'b0;
      ls_cmd_reg   <= '0;
    end else begin
      ls_valid_reg <= host_ls_valid & ~hazard;
      if (host_ls_valid & ~hazard) ls_cmd_reg <= host_ls_cmd;
    end
  end

  assign Compute_valid   = compute_valid_reg;
  assign Compute_command = compute_cmd_reg;
  assign ExLdSt_valid    = ls_valid_reg;
  assign ExLdSt_command  = ls_cmd_reg;
  assign idle            = fifo_empty & (state_reg == ST_IDLE) & ~ls_valid_reg;

`ifdef CIM_SCHED_PERF_EN
  logic [15:0] perf_issued_reg, perf_stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (compute_valid_reg && Compute_ready && (perf_issued_reg != 16'hFFFF))
        perf_issued_reg <= perf_issued_reg + 16'd1;
      if (host_ls_valid && hazard && (perf_stall_reg != 16'hFFFF))
        perf_stall_reg <= perf_stall_reg + 16'd1;
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_cim_cmd_scheduler.sv
// Scoreboard bench for cim_cmd_scheduler: compute and load/store expectations queued on drive, checked on output.
module tb_cim_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_cmp_valid;
  logic        host_cmp_ready;
  logic [24:0] host_cmp_cmd;
  logic        host_ls_valid;
  logic        host_ls_ready;
  logic [6:0]  host_ls_cmd;
  logic        drain;
  logic        idle;
  logic        Compute_valid;
  logic        Compute_ready;
  logic [24:0] Compute_command;
  logic        ExLdSt_valid;
  logic [6:0]  ExLdSt_command;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_cmp_q[$];
  logic [6:0]  exp_ls_q[$];

  always #5 clk = ~clk;

  cim_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .host_cmp_valid(host_cmp_valid), .host_cmp_ready(host_cmp_ready), .host_cmp_cmd(host_cmp_cmd),
    .host_ls_valid(host_ls_valid), .host_ls_ready(host_ls_ready), .host_ls_cmd(host_ls_cmd),
    .drain(drain), .idle(idle),
    .Compute_valid(Compute_valid), .Compute_ready(Compute_ready), .Compute_command(Compute_command),
    .ExLdSt_valid(ExLdSt_valid), .ExLdSt_command(ExLdSt_command)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] mk(input logic sp, input logic [2:0] mode, input logic [2:0] len,
                                     input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd);
    return {sp, mode, len, rs1, rs2, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [24:0] cmd);
    int waited = 0;
    host_cmp_valid = 1'b1;
    host_cmp_cmd   = cmd;
    #1;
    while (!host_cmp_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!host_cmp_ready) check("push_timeout", 32'(host_cmp_ready), 32'd1);
    if (cmd[23:21] != 3'b000) exp_cmp_q.push_back(cmd);
    $display("push cmd 0x%07h", cmd);
    tick();
    host_cmp_valid = 1'b0;
  endtask

  // Drive one load/store probe for a cycle and check the gating decision.
  task automatic ls_probe(input string tag, input logic [6:0] cmd, input logic exp_ready);
    host_ls_valid = 1'b1;
    host_ls_cmd   = cmd;
    #1;
    check(tag, 32'(host_ls_ready), 32'(exp_ready));
    if (exp_ready) exp_ls_q.push_back(cmd);
    $display("ls probe %s cmd 0x%02h ready %0d", tag, cmd, host_ls_ready);
    tick();
    host_ls_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (Compute_valid && Compute_ready) begin
        if (exp_cmp_q.size() == 0) check("cmp_unexpected", 32'(Compute_command), 32'hFFFF_FFFF);
        else begin
          logic [24:0] e;
          e = exp_cmp_q.pop_front();
          check("cmp_order", 32'(Compute_command), 32'(e));
          $display("compute handshake 0x%07h", Compute_command);
        end
      end
      if (ExLdSt_valid) begin
        if (exp_ls_q.size() == 0) check("ls_unexpected", 32'(ExLdSt_command), 32'hFFFF_FFFF);
        else begin
          logic [6:0] e;
          e = exp_ls_q.pop_front();
          check("ls_cmd", 32'(ExLdSt_command), 32'(e));
          $display("ldst issue 0x%02h", ExLdSt_command);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] and_c, mul_c, xor_c, sub_c;
    logic [24:0] fill [6];
    int acc;

    rst_n = 1'b0; host_cmp_valid = 1'b0; host_cmp_cmd = '0; host_ls_valid = 1'b0;
    host_ls_cmd = '0; drain = 1'b0; Compute_ready = 1'b1;
    #3;
    check("rst_cmp_ready", 32'(host_cmp_ready), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_cvalid", 32'(Compute_valid), 32'd0);
    check("rst_ccmd", 32'(Compute_command), 32'd0);
    check("rst_ldst", 32'(ExLdSt_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(host_cmp_ready), 32'd1);

    // Single AND with ready tied high.
    and_c = mk(1'b0, 3'b010, 3'b000, 6'd1, 6'd2, 6'd2);
    push_cmd(and_c);
    check("and_lat1_valid", 32'(Compute_valid), 32'd0);
    check("and_busy", 32'(idle), 32'd0);
    tick();
    check("and_lat2_valid", 32'(Compute_valid), 32'd1);
    check("and_cmd", 32'(Compute_command), 32'(and_c));
    tick();
    check("and_one_cycle", 32'(Compute_valid), 32'd0);
    check("and_idle", 32'(idle), 32'd1);

    // MUL int8 stalls 3 cycles; load/store gating against rd=5 during the stall.
    Compute_ready = 1'b0;
    mul_c = mk(1'b0, 3'b111, 3'b010, 6'd3, 6'd4, 6'd5);
    xor_c = mk(1'b0, 3'b100, 3'b000, 6'd10, 6'd11, 6'd12);
    push_cmd(mul_c);
    push_cmd(xor_c);
    check("mul_valid", 32'(Compute_valid), 32'd1);
    check("mul_cmd0", 32'(Compute_command), 32'(mul_c));
    ls_probe("ls45_blk0", 7'h45, 1'b0);
    check("ls45_no_pulse", 32'(ExLdSt_valid), 32'd0);
    check("mul_cmd1", 32'(Compute_command), 32'(mul_c));
    ls_probe("ls09_pass", 7'h09, 1'b1);
    check("ls09_pulse", 32'(ExLdSt_valid), 32'd1);
    check("mul_cmd2", 32'(Compute_command), 32'(mul_c));
    ls_probe("ls45_blk1", 7'h45, 1'b0);
    check("ls09_single", 32'(ExLdSt_valid), 32'd0);
    check("mul_cmd3", 32'(Compute_command), 32'(mul_c));
    Compute_ready = 1'b1;
    ls_probe("ls45_hs_blk", 7'h45, 1'b0);
    check("xor_next", 32'(Compute_command), 32'(xor_c));
    check("xor_valid", 32'(Compute_valid), 32'd1);
    ls_probe("ls45_after", 7'h45, 1'b1);
    check("ls45_pulse", 32'(ExLdSt_valid), 32'd1);
    check("xor_done", 32'(Compute_valid), 32'd0);
    tick();
    check("ls45_single", 32'(ExLdSt_valid), 32'd0);

    // FIFO fill with the controller stalled: 5 accepted (one in the register), the 6th stalls.
    Compute_ready = 1'b0;
    for (int i = 0; i < 6; i++) fill[i] = mk(1'b0, 3'(1 + (i % 7)), 3'b000, 6'(i), 6'(i + 20), 6'(i + 40));
    acc = 0;
    for (int a = 0; a < 10 && acc < 6; a++) begin
      host_cmp_valid = 1'b1;
      host_cmp_cmd   = fill[acc];
      #1;
      if (!host_cmp_ready) break;
      exp_cmp_q.push_back(fill[acc]);
      $display("fill push %0d cmd 0x%07h", acc, fill[acc]);
      tick();
      acc++;
    end
    host_cmp_valid = 1'b0;
    check("fill_accepts", 32'(acc), 32'd5);
    check("fill_full_ready", 32'(host_cmp_ready), 32'd0);
    Compute_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("fill_no_bubble", 32'(Compute_valid), 32'd1);
      tick();
    end
    check("fill_drained", 32'(Compute_valid), 32'd0);
    check("fill_idle", 32'(idle), 32'd1);

    // Drain blocks acceptance but leaves idle alone; NOP is accepted and dropped.
    drain = 1'b1;
    #1;
    check("drain_ready", 32'(host_cmp_ready), 32'd0);
    check("drain_idle", 32'(idle), 32'd1);
    drain = 1'b0;
    tick();
    push_cmd(mk(1'b0, 3'b000, 3'b000, 6'd1, 6'd2, 6'd3));
    tick(); tick();
    check("nop_dropped", 32'(Compute_valid), 32'd0);
    check("nop_idle", 32'(idle), 32'd1);

    // SUB special rd=6 / rs2=30: pair columns blocked, rs1 exact only.
    Compute_ready = 1'b0;
    sub_c = mk(1'b1, 3'b110, 3'b000, 6'd20, 6'd30, 6'd6);
    push_cmd(sub_c);
    tick();
    ls_probe("sub_col6", 7'h06, 1'b0);
    ls_probe("sub_col7_pair", 7'h07, 1'b0);
    ls_probe("sub_col31_pair", 7'h1F, 1'b0);
    ls_probe("sub_col21_rs1", 7'h15, 1'b1);
    ls_probe("sub_col8", 7'h48, 1'b1);
    Compute_ready = 1'b1;
    tick(); tick();
    // Non-special SUB: no pair widening.
    Compute_ready = 1'b0;
    push_cmd(mk(1'b0, 3'b110, 3'b000, 6'd20, 6'd30, 6'd6));
    tick();
    ls_probe("sub_ns_col7", 7'h07, 1'b1);
    ls_probe("sub_ns_col6", 7'h06, 1'b0);
    Compute_ready = 1'b1;
    tick(); tick();

    // Reset mid-MUL: outputs drop asynchronously, nothing survives.
    Compute_ready = 1'b0;
    push_cmd(mul_c);
    host_ls_valid = 1'b1;
    host_ls_cmd   = 7'h01;
    tick();
    host_ls_valid = 1'b0;
    check("rmul_valid", 32'(Compute_valid), 32'd1);
    check("rmul_ldst", 32'(ExLdSt_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    exp_cmp_q.delete();
    #1;
    check("async_cvalid", 32'(Compute_valid), 32'd0);
    check("async_ldst", 32'(ExLdSt_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    Compute_ready = 1'b1;
    tick();
    check("rr_idle", 32'(idle), 32'd1);
    check("rr_ccmd", 32'(Compute_command), 32'd0);
    check("rr_ready", 32'(host_cmp_ready), 32'd1);
    tick(); tick();
    check("rr_no_stale", 32'(Compute_valid), 32'd0);

    check("cmp_q_empty", 32'(exp_cmp_q.size()), 32'd0);
    check("ls_q_empty", 32'(exp_ls_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
